// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART transmitter/receiver pair: baud-rate
// derivation, a ceil-log2 helper for counter sizing, and the receiver state
// encoding. One tx/rx pair built from the same CLK_FREQ_KHz/BAUD_RATE_BPS
// therefore agrees on the bit period by construction.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    // Receiver state, one-hot so each state decodes from a single bit.
    typedef logic [4:0] status_t;

    localparam status_t ST_IDLE     = 5'b00001;
    localparam status_t ST_START    = 5'b00010;
    localparam status_t ST_DATA     = 5'b00100;
    localparam status_t ST_STOP     = 5'b01000;
    localparam status_t ST_RECOVER  = 5'b10000;

    // Smallest width able to hold 'value' distinct codes, never below 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Clocks per bit, integer-truncated.
    function automatic int bit_clocks(input int clk_freq_khz, input int baud_rate_bps);
        return int'((longint'(clk_freq_khz) * 1000) / baud_rate_bps);
    endfunction

    // Clocks from the start edge to the middle of the start bit.
    function automatic int half_clocks(input int bit_clks);
        return bit_clks / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Output lags the
// input by two clocks. Reset value is a parameter so idle-high lines (UART)
// and idle-low lines can share the block.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    // NOTE: non-blocking assignments make r_q take the pre-edge r_meta, giving a
    // real two-stage chain; blocking here would collapse it to one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The serial line is synchronised, a falling edge is
// qualified by re-sampling at mid start bit, then each data bit (LSB first)
// and the stop bit are sampled at mid-bit. No oversampling or voting.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   data      : last good byte, held until the next good byte
//   data_en   : one-cycle strobe, data updated this cycle
//   frame_err : one-cycle strobe, stop bit sampled low, byte discarded
//   rx_busy   : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_CLOCKS  = bit_clocks(CLK_FREQ_KHz, BAUD_RATE_BPS);
    localparam int HALF_CLOCKS = half_clocks(BIT_CLOCKS);
    localparam int CNT_W       = clog2(BIT_CLOCKS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLOCKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLOCKS - 1);

    logic             w_rx_s;
    logic             w_bit_done;
    logic             w_half_done;

    status_t          r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_data_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_data_en;
    logic             r_frame_err;

    // The line idles high, so the synchroniser resets high to avoid a false
    // start bit straight out of reset.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    assign w_bit_done  = (r_bit_cnt == BIT_LAST);
    assign w_half_done = (r_bit_cnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_data_cnt  <= '0;
            r_data      <= '0;
            r_data_en   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each is exactly one
            // cycle wide; only the stop-bit decision below raises one.
            r_data_en   <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_data_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                    end
                end

                // Re-check the line at mid start bit; a short low pulse is
                // treated as noise and dropped silently.
                ST_START: begin
                    if (w_half_done) begin
                        r_bit_cnt <= '0;
                        r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                // Counting restarts at mid start bit, so every BIT_CLOCKS
                // later lands at mid data bit.
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (r_data_cnt == 3'd7) begin
                            r_data_cnt <= '0;
                            r_state    <= ST_STOP;
                        end else begin
                            r_data_cnt <= r_data_cnt + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                // Deciding at mid stop bit returns to Idle half a bit early,
                // so a start bit directly after the stop bit is not missed.
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (w_rx_s) begin
                            r_data    <= r_shift;
                            r_data_en <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_RECOVER;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                // After a framing error the line may sit low (break or fault);
                // only a return to high re-arms start detection.
                ST_RECOVER: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the shift register has no reset; it is only published after eight
    // fresh samples have been shifted in, so its start value never escapes.
    always_ff @(posedge clk) begin
        if ((r_state == ST_DATA) && w_bit_done) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

    assign data      = r_data;
    assign data_en   = r_data_en;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 10 clocks per bit. Frames are generated
// bit by bit from a byte value and a bit period in tenths of a clock; the
// expected outcome of each frame (good byte, or framing error with the last
// good byte still held) is queued and compared with what the receiver emits.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ_KHZ  = 1000;
    localparam int BAUD_RATE_BPS = 100000;
    localparam int BIT_CLK       = 10;
    localparam int HALF_CLK      = 5;
    // Line fall -> strobe: 2 synchroniser clocks + 1 detect edge, half a bit
    // to mid start, then 8 data bits and the stop bit.
    localparam int LATENCY       = 3 + HALF_CLK + 9 * BIT_CLK;

    typedef struct packed {
        logic       is_err;
        logic [7:0] val;
    } event_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_en;
    logic       frame_err;
    logic       rx_busy;

    event_t     exp_q[$];
    event_t     obs_q[$];
    logic [7:0] exp_last = 8'h00;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         en_cyc   = 0;
    int         busy_cnt = 0;

    logic       rst_q     = 1'b1;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx #(
        .CLK_FREQ_KHz  (CLK_FREQ_KHZ),
        .BAUD_RATE_BPS (BAUD_RATE_BPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_en   (data_en),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output monitor: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        event_t ev;
        if (data_en || frame_err) begin
            ev.is_err = frame_err;
            ev.val    = data;
            obs_q.push_back(ev);
            check("strobe_exclusive", {31'd0, data_en & frame_err}, 32'd0);
        end
        if (data_en) begin
            en_cyc = cyc;
            check("busy_falls_with_data_en", {30'd0, prev_busy, rx_busy}, 32'd2);
        end
        if (!rst_q && (data !== prev_data)) begin
            check("data_changes_only_on_data_en", {31'd0, data_en}, 32'd1);
        end
        if (rx_busy) begin
            busy_cnt++;
        end
        prev_busy = rx_busy;
        prev_data = data;
    end

    task automatic send_bit(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic idle(input int clocks);
        send_bit(1'b1, clocks);
    endtask

    // One 8N1 frame; bit boundaries placed at round-down multiples of
    // tenths/10 clocks so non-integer baud ratios average out correctly.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int tenths);
        logic [9:0] bits;
        int dur;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            dur = ((k + 1) * tenths) / 10 - (k * tenths) / 10;
            send_bit(bits[k], dur);
        end
    endtask

    task automatic push_good(input logic [7:0] b);
        event_t ev;
        ev.is_err = 1'b0;
        ev.val    = b;
        exp_q.push_back(ev);
        exp_last = b;
    endtask

    task automatic push_err();
        event_t ev;
        ev.is_err = 1'b1;
        ev.val    = exp_last;
        exp_q.push_back(ev);
    endtask

    task automatic compare_events(input string tag);
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, {31'd0, obs_q[i].is_err}, {31'd0, exp_q[i].is_err});
            check({tag, "_data"}, {24'd0, obs_q[i].val}, {24'd0, exp_q[i].val});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] loop_bytes [4];
        logic [7:0] c3;
        logic [7:0] b;
        int t_fall;
        int tenths;
        int gap;
        logic bad;

        loop_bytes = '{8'h00, 8'hFF, 8'h55, 8'h81};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_data_en", {31'd0, data_en}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Single byte with latency check
        push_good(8'hA5);
        t_fall = cyc;
        send_frame(8'hA5, 1'b1, 100);
        idle(10);
        check("single_latency", en_cyc - t_fall, LATENCY);
        check("single_idle_after", {31'd0, rx_busy}, 32'd0);
        compare_events("single");

        // Back-to-back frames, no idle between stop and next start
        foreach (loop_bytes[i]) begin
            push_good(loop_bytes[i]);
            send_frame(loop_bytes[i], 1'b1, 100);
        end
        idle(15);
        compare_events("loopback");

        // Random bytes, slight baud skew, occasional bad stop bit
        for (int f = 0; f < 12; f++) begin
            b      = 8'($urandom);
            bad    = ($urandom_range(0, 5) == 0);
            tenths = $urandom_range(97, 103);
            gap    = bad ? 12 : $urandom_range(0, 3);
            if (bad) push_err();
            else     push_good(b);
            send_frame(b, !bad, tenths);
            if (gap > 0) idle(gap);
        end
        idle(15);
        compare_events("random");

        // Glitch shorter than half a bit
        busy_cnt = 0;
        send_bit(1'b0, 3);
        idle(20);
        check("glitch_busy_cycles", busy_cnt, HALF_CLK);
        check("glitch_events", obs_q.size(), 0);
        push_good(8'h3C);
        send_frame(8'h3C, 1'b1, 100);
        idle(15);
        compare_events("after_glitch");

        // Framing error followed by a stuck-low line
        push_err();
        send_frame(8'h7E, 1'b0, 100);
        send_bit(1'b0, 30);
        check("recover_holds_while_low", {31'd0, rx_busy}, 32'd1);
        idle(5);
        check("recover_exits_on_high", {31'd0, rx_busy}, 32'd0);
        idle(20);
        check("no_false_start", {31'd0, rx_busy}, 32'd0);
        compare_events("frame_err");

        // Reset during data bit 4
        c3 = 8'hC3;
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(c3[i], BIT_CLK);
        rx = c3[4];
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_data_en", {31'd0, data_en}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        exp_last = 8'h00;
        idle(20);
        push_good(8'h12);
        send_frame(8'h12, 1'b1, 100);
        idle(15);
        compare_events("after_reset");

        // Slow transmitter, 10.4 clocks per bit
        push_good(8'h96);
        send_frame(8'h96, 1'b1, 104);
        idle(15);
        compare_events("baud_skew");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the existing UART transmitter on the serial link.
- Consumes the asynchronous serial line, synchronises it, validates the start bit, and samples at mid-bit, LSB first.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Uses the same baud-rate parameterisation as the transmitter, so one tx/rx pair shares a single configuration.

Parameters:
- CLK_FREQ_KHz, 50000, system clock frequency in kHz.
- BAUD_RATE_BPS, 115200, line rate in bits/s.
- BIT_CLOCKS (derived, not overridable), (CLK_FREQ_KHz*1000)/BAUD_RATE_BPS, clocks per bit, integer-truncated.
- HALF_CLOCKS (derived), BIT_CLOCKS/2, clocks from start edge to mid start bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx  in  1  asynchronous serial line; idle high.
- data  out  8  last received byte; holds until next valid byte.
- data_en  out  1  one-cycle pulse: data updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- rx_busy  out  1  high in every state except Idle.

Behaviour:
- Reset values: data=0x00, data_en=0, frame_err=0, rx_busy=0.
- Reset also sets state=Idle, bitClkCnt=0, dataBitCnt=0, both synchroniser flops=1.
- Reset has priority in any state. A reset mid-frame abandons the byte with no data_en and no frame_err.
- Synchroniser: rx passes through 2 flops to give rx_s (2-cycle latency). All decisions below use rx_s only.
- bitClkCnt width is clog2(BIT_CLOCKS). Counter compares use BIT_CLOCKS-1 and HALF_CLOCKS-1. dataBitCnt is 3 bits and wraps 7->0.
- States (one-hot enum Status): Idle, StartBit, DataBits, StopBit, Recover.
- Idle:
  - bitClkCnt=0, dataBitCnt=0.
  - rx_s==0 -> StartBit.
- StartBit:
  - bitClkCnt counts 0..HALF_CLOCKS-1.
  - At HALF_CLOCKS-1 with rx_s==0: cnt=0 -> DataBits.
  - At HALF_CLOCKS-1 with rx_s==1: glitch; -> Idle, no output pulse.
- DataBits:
  - bitClkCnt counts 0..BIT_CLOCKS-1.
  - At BIT_CLOCKS-1: cnt=0, shiftData <= {rx_s, shiftData[7:1]}.
  - If dataBitCnt==7: dataBitCnt=0 -> StopBit. Else dataBitCnt+1.
- StopBit:
  - bitClkCnt counts 0..BIT_CLOCKS-1.
  - At BIT_CLOCKS-1 with rx_s==1: data<=shiftData, data_en<=1 for one cycle -> Idle.
  - At BIT_CLOCKS-1 with rx_s==0: frame_err<=1 for one cycle, data unchanged -> Recover.
- Recover:
  - Waits for rx_s==1 (break or stuck-low line), then -> Idle.
  - A low line never produces a false start here.
- data_en and frame_err are never both high. Each is low in every cycle other than its single pulse.
- Latency: let E0 be the edge at which Idle sees rx_s==0. data_en/frame_err are high in the cycle after edge E0+HALF_CLOCKS+9*BIT_CLOCKS.
- Back-to-back frames:
  - Receiver is in Idle HALF_CLOCKS early relative to the transmitter's stop bit end.
  - A start bit arriving immediately after the stop bit is accepted with no lost byte.
- Sampling at mid-bit tolerates cumulative baud mismatch below roughly ±4% over a frame. No oversampling or majority vote.

Decomposition:
- Shared package (common with the transmitter):
  - Status-style enum for rx states.
  - BIT_CLOCKS and HALF_CLOCKS derivation.
  - clog2 helper.
- One natural sub-module: sync_2ff.
  - Ports: clk, rst, d, q.
  - Reset value is a parameter; 1 here.
  - Reusable for any async input.

Test Plan (bench params CLK_FREQ_KHz=1000, BAUD_RATE_BPS=100000, giving BIT_CLOCKS=10, HALF_CLOCKS=5):
- Single byte: drive 8N1 frame 0xA5 at 10 clk/bit -> exactly one data_en pulse with data=0xA5, frame_err never high, rx_busy falls with data_en.
- Loopback: transmitter tx -> rx; send 0x00, 0xFF, 0x55, 0x81 back-to-back, each on tx_done -> four data_en pulses in order with matching bytes, none lost.
- Glitch: rx low for 3 clocks then high -> returns to Idle after 5 StartBit cycles, no data_en/frame_err; a following frame 0x3C is received correctly.
- Framing error: frame 0x7E with stop bit low, then line held low 30 clocks -> one frame_err pulse, data keeps the previous value, stays in Recover until rx high, no spurious start.
- Reset mid-frame: assert rst during data bit 4 of 0xC3 -> outputs and state at reset values next cycle, no pulses; the next full frame 0x12 is received correctly.
- Baud skew: drive frame 0x96 at 10.4 clk/bit average -> data=0x96 received without error.
